// File: rtl/packet_sender_fifo.sv
// rtl/packet_sender_fifo.sv - queued multi-slot serial packet sender (header + SLOTS data slots per tick)
module packet_sender_fifo #(
  parameter int DATA_W = 40,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP = 3,
  parameter int SLOTS = 2,
  parameter logic [DATA_W-1:0] REQ_WORD = DATA_W'(40'h0700000000)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             in_data_valid,
  output logic                             in_data_ready,
  output logic                             data_retrieved,
  output logic                             data_loss,
  input  logic                             audio_sample_request_mode,
  input  logic                             audio_sample_request_tick,
  output logic                             tick_missed,
  output logic                             sout,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(DATA_W + GAP + 1);
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_GAP, S_SLOT} state_t;

  state_t            r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [SW-1:0]     r_slot, w_slot_nxt;
  logic [DATA_W:0]   r_shift, w_shift_nxt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_data_loss, r_tick_missed;
  logic              w_full, w_empty, w_pop, w_push;

  assign w_full         = (r_level == LW'(FIFO_DEPTH));
  assign w_empty        = (r_level == '0);
  assign in_data_ready  = !w_full || w_pop;
  assign w_push         = in_data_valid && in_data_ready;
  assign data_retrieved = w_push;
  assign data_loss      = r_data_loss;
  assign tick_missed    = r_tick_missed;
  assign fifo_level     = r_level;
  assign busy           = (r_state != S_IDLE);
  // The shift register drains to zero after each slot, so gaps and idle emit 0 for free.
  assign sout           = r_shift[DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_slot  <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_slot  <= w_slot_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_slot_nxt  = r_slot;
    w_shift_nxt = {r_shift[DATA_W-1:0], 1'b0};
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (audio_sample_request_tick) begin
          w_state_nxt = S_HEADER;
          w_shift_nxt = audio_sample_request_mode ? {1'b1, REQ_WORD} : '0;
        end
      end
      S_HEADER: begin
        if (r_cnt == CW'(DATA_W)) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
          w_slot_nxt  = '0;
        end
      end
      S_GAP: begin
        if (r_cnt == CW'(GAP - 1)) begin
          w_state_nxt = S_SLOT;
          w_cnt_nxt   = '0;
          w_pop       = !w_empty;
          w_shift_nxt = w_empty ? '0 : {1'b1, r_mem[r_rd_ptr]};
        end
      end
      S_SLOT: begin
        if (r_cnt == CW'(DATA_W)) begin
          w_cnt_nxt = '0;
          if (r_slot == SW'(SLOTS - 1)) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_GAP;
            w_slot_nxt  = r_slot + SW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_data_loss   <= 1'b0;
      r_tick_missed <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
      r_data_loss   <= in_data_valid && !in_data_ready;
      r_tick_missed <= audio_sample_request_tick && (r_state != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_packet_sender_fifo.sv
// tb/tb_packet_sender_fifo.sv - self-checking bench for packet_sender_fifo against a queue-based frame model
module tb_packet_sender_fifo;
  localparam int DW    = 40;
  localparam int DEPTH = 4;
  localparam int GAPC  = 3;
  localparam int NSLOT = 2;
  localparam int SW    = DW + 1;
  localparam int FL    = SW * (1 + NSLOT) + GAPC * NSLOT;
  localparam int P0    = SW + GAPC;
  localparam int P1    = P0 + SW + GAPC;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] REQ = 40'h0700000000;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_data_valid;
  logic          in_data_ready;
  logic          data_retrieved;
  logic          data_loss;
  logic          audio_sample_request_mode;
  logic          audio_sample_request_tick;
  logic          tick_missed;
  logic          sout;
  logic          busy;
  logic [LW-1:0] fifo_level;

  always #5 clk = ~clk;

  packet_sender_fifo #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .GAP(GAPC), .SLOTS(NSLOT), .REQ_WORD(REQ)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_data_valid(in_data_valid),
    .in_data_ready(in_data_ready),
    .data_retrieved(data_retrieved),
    .data_loss(data_loss),
    .audio_sample_request_mode(audio_sample_request_mode),
    .audio_sample_request_tick(audio_sample_request_tick),
    .tick_missed(tick_missed),
    .sout(sout),
    .busy(busy),
    .fifo_level(fifo_level)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] model_q[$];
  logic [FL-1:0] obs;
  logic          busy_log [0:FL];
  logic          dl_log   [0:FL];
  logic          tm_log   [0:FL];
  logic          dr_log   [0:FL];
  int            lvl_log  [0:FL];

  // Reference frame: header, then per slot GAP zeros and either {1,word} or all zeros.
  function automatic logic [FL-1:0] exp_frame(input bit mode);
    logic [FL-1:0] f;
    logic [SW-1:0] s;
    s = mode ? {1'b1, REQ} : '0;
    f = FL'(s);
    for (int k = 0; k < NSLOT; k++) begin
      f = f << GAPC;
      if (model_q.size() > 0) s = {1'b1, model_q.pop_front()};
      else s = '0;
      f = (f << SW) | FL'(s);
    end
    return f;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    return DW'({$urandom, $urandom});
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [DW-1:0] w, output logic dr, output logic rdy, output logic dl);
    in_data = w;
    in_data_valid = 1'b1;
    #1;
    dr  = data_retrieved;
    rdy = in_data_ready;
    @(posedge clk);
    #1;
    in_data_valid = 1'b0;
    #1;
    dl = data_loss;
  endtask

  // Tick in the current cycle (cycle 0) and log outputs for cycles 0..FL; mode is scrambled mid-frame.
  task automatic run_frame(input bit mode, input int miss_at, input int push_at,
                           input logic [DW-1:0] pw, input int rst_at);
    audio_sample_request_mode = mode;
    audio_sample_request_tick = 1'b1;
    #1;
    busy_log[0] = busy; lvl_log[0] = int'(fifo_level); dl_log[0] = data_loss;
    tm_log[0] = tick_missed; dr_log[0] = data_retrieved;
    obs = '0;
    for (int c = 1; c <= FL; c++) begin
      @(posedge clk);
      #1;
      audio_sample_request_tick = (c == miss_at);
      audio_sample_request_mode = 1'($urandom_range(0, 1));
      in_data_valid = (c == push_at);
      in_data = pw;
      rst = (c == rst_at);
      #1;
      obs = {obs[FL-2:0], sout};
      busy_log[c] = busy; lvl_log[c] = int'(fifo_level); dl_log[c] = data_loss;
      tm_log[c] = tick_missed; dr_log[c] = data_retrieved;
    end
    audio_sample_request_tick = 1'b0;
    in_data_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) next_cycle();
    rst = 1'b0;
    #1;
    n_tests++; if (sout !== 1'b0) begin n_fail++; $display("FAIL reset_sout: got %b expected 0", sout); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (data_loss !== 1'b0) begin n_fail++; $display("FAIL reset_data_loss: got %b expected 0", data_loss); end
    n_tests++; if (tick_missed !== 1'b0) begin n_fail++; $display("FAIL reset_tick_missed: got %b expected 0", tick_missed); end
    n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    n_tests++; if (in_data_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_data_ready); end
  endtask

  task automatic test_empty_frame();
    logic [FL-1:0] exp;
    int bad_busy, bad_other;
    next_cycle();
    exp = exp_frame(1'b0);
    run_frame(1'b0, 0, 0, '0, 0);
    bad_busy = (busy_log[0] !== 1'b0) ? 1 : 0;
    bad_other = 0;
    for (int c = 1; c <= FL; c++) if (busy_log[c] !== 1'b1) bad_busy++;
    for (int c = 0; c <= FL; c++) if (lvl_log[c] != 0 || dl_log[c] !== 1'b0) bad_other++;
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL empty_frame_sout: got %h expected %h", obs, exp); end
    n_tests++; if (bad_busy != 0) begin n_fail++; $display("FAIL empty_frame_busy: got %0d bad cycles expected 0", bad_busy); end
    n_tests++; if (bad_other != 0) begin n_fail++; $display("FAIL empty_frame_level_loss: got %0d bad cycles expected 0", bad_other); end
  endtask

  task automatic test_data_frame();
    logic [FL-1:0] exp;
    logic dr, rdy, dl;
    int bad;
    logic [DW-1:0] words [2];
    words[0] = 40'hD999999991;
    words[1] = 40'hD999999993;
    next_cycle();
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      push_one(words[i], dr, rdy, dl);
      model_q.push_back(words[i]);
      if (dr !== 1'b1 || dl !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL data_push: got %0d bad pushes expected 0", bad); end
    next_cycle();
    exp = exp_frame(1'b1);
    run_frame(1'b1, 0, 0, '0, 0);
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL data_frame_sout: got %h expected %h", obs, exp); end
    n_tests++;
    if (lvl_log[P0] != 2 || lvl_log[P0+1] != 1 || lvl_log[P1] != 1 || lvl_log[P1+1] != 0) begin
      n_fail++;
      $display("FAIL data_frame_level: got %0d,%0d,%0d,%0d expected 2,1,1,0",
               lvl_log[P0], lvl_log[P0+1], lvl_log[P1], lvl_log[P1+1]);
    end
  endtask

  task automatic test_back_to_back();
    logic dr, rdy, dl;
    logic [DW-1:0] w;
    bit acc;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      w = rand_word();
      acc = (model_q.size() < DEPTH);
      push_one(w, dr, rdy, dl);
      if (acc) model_q.push_back(w);
      n_tests++;
      if (dr !== acc || rdy !== acc || dl !== !acc) begin
        n_fail++;
        $display("FAIL b2b_word%0d: got dr=%b rdy=%b loss=%b expected dr=%b rdy=%b loss=%b",
                 i, dr, rdy, dl, acc, acc, !acc);
      end
    end
    next_cycle();
    #1;
    n_tests++; if (data_loss !== 1'b0) begin n_fail++; $display("FAIL b2b_loss_single: got %b expected 0", data_loss); end
    n_tests++; if (int'(fifo_level) != DEPTH) begin n_fail++; $display("FAIL b2b_level: got %0d expected %0d", fifo_level, DEPTH); end
  endtask

  task automatic test_full_push_on_pop();
    logic [FL-1:0] exp;
    logic [DW-1:0] w;
    bit m;
    next_cycle();
    w = rand_word();
    m = 1'($urandom_range(0, 1));
    exp = exp_frame(m);
    model_q.push_back(w);
    run_frame(m, 0, P0, w, 0);
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL popcycle_sout: got %h expected %h", obs, exp); end
    n_tests++;
    if (dr_log[P0] !== 1'b1 || dl_log[P0+1] !== 1'b0) begin
      n_fail++;
      $display("FAIL popcycle_accept: got dr=%b loss=%b expected dr=1 loss=0", dr_log[P0], dl_log[P0+1]);
    end
    n_tests++;
    if (lvl_log[P0+1] != DEPTH || lvl_log[P1+1] != DEPTH - 1) begin
      n_fail++;
      $display("FAIL popcycle_level: got %0d,%0d expected %0d,%0d", lvl_log[P0+1], lvl_log[P1+1], DEPTH, DEPTH - 1);
    end
  endtask

  task automatic test_tick_missed();
    logic [FL-1:0] exp;
    int pulses;
    bit m;
    next_cycle();
    m = 1'($urandom_range(0, 1));
    exp = exp_frame(m);
    run_frame(m, 60, 0, '0, 0);
    pulses = 0;
    for (int c = 0; c <= FL; c++) if (tm_log[c] === 1'b1) pulses++;
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL missed_frame_sout: got %h expected %h", obs, exp); end
    n_tests++;
    if (tm_log[61] !== 1'b1 || pulses != 1) begin
      n_fail++;
      $display("FAIL tick_missed_pulse: got at61=%b pulses=%0d expected 1,1", tm_log[61], pulses);
    end
    n_tests++; if (busy_log[FL] !== 1'b1) begin n_fail++; $display("FAIL missed_frame_end_busy: got %b expected 1", busy_log[FL]); end
    next_cycle();
    m = 1'($urandom_range(0, 1));
    exp = exp_frame(m);
    run_frame(m, 0, 0, '0, 0);
    n_tests++;
    if (busy_log[0] !== 1'b0 || busy_log[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_busy: got %b%b expected 01", busy_log[0], busy_log[1]);
    end
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL restart_frame_sout: got %h expected %h", obs, exp); end
  endtask

  task automatic test_midframe_reset();
    logic [FL-1:0] exp;
    logic dr, rdy, dl;
    logic [DW-1:0] w;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      w = rand_word();
      push_one(w, dr, rdy, dl);
      model_q.push_back(w);
    end
    next_cycle();
    exp = exp_frame(1'b1);
    run_frame(1'b1, 0, 0, '0, 70);
    model_q.delete();
    n_tests++;
    if (obs[FL-1 -: 70] !== exp[FL-1 -: 70] || obs[FL-71:0] !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_sout: got %h expected upper 70 bits of %h then zeros", obs, exp);
    end
    n_tests++;
    if (busy_log[71] !== 1'b0 || lvl_log[71] != 0 || lvl_log[70] != 2) begin
      n_fail++;
      $display("FAIL reset_mid_state: got busy=%b lvl70=%0d lvl71=%0d expected 0,2,0", busy_log[71], lvl_log[70], lvl_log[71]);
    end
    next_cycle();
    exp = exp_frame(1'b1);
    run_frame(1'b1, 0, 0, '0, 0);
    n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL post_reset_frame: got %h expected %h", obs, exp); end
  endtask

  task automatic test_random();
    logic [FL-1:0] exp;
    logic dr, rdy, dl;
    logic [DW-1:0] w;
    bit acc, m;
    int n, bad;
    for (int it = 0; it < 4; it++) begin
      next_cycle();
      n = $urandom_range(0, 5);
      bad = 0;
      for (int i = 0; i < n; i++) begin
        w = rand_word();
        acc = (model_q.size() < DEPTH);
        push_one(w, dr, rdy, dl);
        if (acc) model_q.push_back(w);
        if (dr !== acc || dl !== !acc) bad++;
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rand%0d_push: got %0d bad pushes expected 0", it, bad); end
      next_cycle();
      m = 1'($urandom_range(0, 1));
      exp = exp_frame(m);
      run_frame(m, 0, 0, '0, 0);
      n_tests++; if (obs !== exp) begin n_fail++; $display("FAIL rand%0d_sout: got %h expected %h", it, obs, exp); end
      n_tests++;
      if (lvl_log[FL] != model_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_level: got %0d expected %0d", it, lvl_log[FL], model_q.size());
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0;
    in_data_valid = 1'b0;
    audio_sample_request_mode = 1'b0;
    audio_sample_request_tick = 1'b0;
    test_reset();
    test_empty_frame();
    test_data_frame();
    test_back_to_back();
    test_full_push_on_pop();
    test_tick_missed();
    test_midframe_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/packet_sender_fifo.md
Name: packet_sender_fifo

Overview:
- Parametrised successor to the single-buffer serial packet sender.
- Queues up to FIFO_DEPTH outgoing data words. On each audio-sample-request tick it serialises one frame onto `sout`:
  - one header slot (audio sample request packet, or silence),
  - then SLOTS data slots, each carrying one queued word.
- Sits between the command/keyboard/audio packet producers and the serial line to the host asic.

Parameters:
- DATA_W, 40, payload bits per packet; each slot is 1 start bit + DATA_W bits.
- FIFO_DEPTH, 4, queued words (power of two, >=2).
- GAP, 3, zero bit-cycles inserted before each data slot.
- SLOTS, 2, data slots per frame (>=1).
- REQ_WORD, 40'h0700000000, header payload when request mode is set (width DATA_W).

Ports:
- clk  in  1  system clock, one bit per cycle on `sout`.
- rst  in  1  synchronous active-high reset.
- in_data  in  DATA_W  word to queue.
- in_data_valid  in  1  producer offers `in_data` this cycle.
- in_data_ready  out  1  combinational: `!full || pop_now`.
- data_retrieved  out  1  combinational: `in_data_valid && in_data_ready`, i.e. the word is accepted this cycle.
- data_loss  out  1  registered one-cycle pulse, a word was dropped.
- audio_sample_request_mode  in  1  header type, sampled at tick.
- audio_sample_request_tick  in  1  one-cycle frame start strobe.
- tick_missed  out  1  registered one-cycle pulse, tick arrived while busy.
- sout  out  1  registered serial output, MSB first.
- busy  out  1  high from first header bit to last frame bit.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  current queue occupancy.

Behaviour:
- Reset values: sout=0, busy=0, data_loss=0, tick_missed=0, fifo_level=0. FIFO is flushed, state=IDLE, bit counter=0.
- Reset mid-frame aborts the frame immediately: sout=0 on the next cycle and queued words are discarded.
- States:
  - IDLE → HEADER → (GAP → SLOT) × SLOTS → IDLE.
  - A single bit counter tracks position within each state.
- IDLE:
  - sout=0.
  - Tick at cycle 0: latch mode and load the shift register with {1, REQ_WORD} if mode=1, or all zeros if mode=0.
  - Go to HEADER; busy=1 from cycle 1.
- HEADER: DATA_W+1 cycles, shifting MSB first. With defaults, sout carries bits on cycles 1..41.
- GAP: GAP cycles, sout=0. With defaults, cycles 42..44.
- Slot load (pop_now) happens on the last GAP cycle:
  - FIFO non-empty: pop the head word and load {1, word}.
  - FIFO empty: load all zeros (41 zero bits sent), no pop.
- SLOT: DATA_W+1 cycles. With defaults, slot0 occupies cycles 45..85, gap 86..88, slot1 89..129.
- Frame end:
  - After the last SLOT bit, return to IDLE; busy=0 from cycle 130.
  - A tick at cycle 130 starts a new frame.
  - Frame length = (DATA_W+1)*(1+SLOTS) + GAP*SLOTS cycles.
- Ticks while busy: ignored; tick_missed pulses on the next cycle.
- Mode changes mid-frame have no effect until the next tick.
- FIFO push/pop:
  - Push when valid && ready.
  - Push while full with no pop that cycle: word dropped, data_loss=1 next cycle, fifo_level unchanged.
  - Simultaneous push+pop while full: accepted, level unchanged.
  - Simultaneous push+pop while not full: level unchanged.
  - Order is strictly FIFO. Pointers wrap modulo FIFO_DEPTH.
- in_data_valid may be high for consecutive cycles; one word is accepted per cycle.

Test Plan:
- Reset, then tick with mode=0 and empty FIFO → sout=0 for all 130 cycles; busy high cycles 1..129; fifo_level=0; no data_loss.
- Push A=40'hD999999991, B=40'hD999999993 in IDLE, then tick with mode=1:
  - cycles 1..41 carry 1,0x0700000000;
  - cycles 45..85 carry 1,A;
  - cycles 89..129 carry 1,B;
  - fifo_level goes 2→1 after cycle 44 and →0 after cycle 88.
- Push 5 words back-to-back while idle with DEPTH=4:
  - first 4 accepted with data_retrieved=1;
  - 5th sees in_data_ready=0, data_loss pulses once;
  - fifo_level=4.
- FIFO full during a frame, push held on the pop cycle (cycle 44) → accepted, data_loss=0, fifo_level stays 4.
- Tick pulses at cycle 60 of a frame → tick_missed pulses at cycle 61; the frame still ends at cycle 129; a tick at cycle 130 starts a new header at 131.
- Assert rst at cycle 70 with 3 words queued → sout=0, busy=0, fifo_level=0 next cycle; a following tick sends a zero-payload frame.
